// File: rtl/icache_dm_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_dm_pkg;

    // Refill controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        RETRY  = 2'd2
    } icache_state_e;

    // Instruction fetches always read whole 32-bit words.
    localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/icache_dm_if.sv
// Wishbone classic bus bundle between the instruction cache (master) and memory (slave).
interface icache_dm_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_cyc_o;
    logic        wb_rty_i;
    logic        wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i, wb_rty_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i, wb_rty_i, wb_err_i
    );
endinterface

// File: rtl/icache_dm_refill_fsm.sv
// Line-refill controller: Wishbone classic handshake, word counter and the
// fence-pending flag that keeps a line refilled across a fence.i invalid.
module icache_dm_refill_fsm
    import icache_dm_pkg::*;
#(
    parameter int WORDS_PER_LINE = 4,
    parameter int OFF_W          = 2,
    parameter int LINE_W         = 30 - OFF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,        // fetch valid and lookup missed
    input  logic [LINE_W-1:0] i_line,        // pc_i line number (pc_i[31:OFF_W+2])
    input  logic              i_fence,
    input  logic              i_ack,
    input  logic              i_rty,
    input  logic              i_err,
    output icache_state_e     o_state,
    output logic              o_start,       // IDLE -> REFILL this cycle
    output logic              o_word_we,     // store wb data into word o_word of the line
    output logic              o_line_done,   // final word accepted: write tag
    output logic              o_install_valid,
    output logic [OFF_W-1:0]  o_word,
    output logic [LINE_W-1:0] o_line,
    output logic [31:0]       o_adr,
    output logic              o_cyc,
    output logic              o_stb,
    output logic              o_err
);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    icache_state_e     r_state, w_state_next;
    logic [OFF_W-1:0]  r_word, w_word_next;
    logic [LINE_W-1:0] r_line, w_line_next;
    logic [31:0]       r_adr, w_adr_next;
    logic              r_fence_pend, w_fence_next;
    logic              r_err, w_err_next;

    // State and datapath registers; reset drops the bus cycle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_line       <= '0;
            r_adr        <= '0;
            r_fence_pend <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_word       <= w_word_next;
            r_line       <= w_line_next;
            r_adr        <= w_adr_next;
            r_fence_pend <= w_fence_next;
            r_err        <= w_err_next;
        end
    end

    // Next-state logic; bus responses are prioritised err > rty > ack.
    always_comb begin
        w_state_next    = r_state;
        w_word_next     = r_word;
        w_line_next     = r_line;
        w_adr_next      = r_adr;
        w_fence_next    = r_fence_pend;
        w_err_next      = 1'b0;
        o_start         = 1'b0;
        o_word_we       = 1'b0;
        o_line_done     = 1'b0;
        o_install_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_miss) begin
                    o_start      = 1'b1;
                    w_line_next  = i_line;
                    w_adr_next   = {i_line, {(OFF_W + 2){1'b0}}};
                    w_word_next  = '0;
                    w_state_next = REFILL;
                end
            end
            REFILL: begin
                if (i_fence) w_fence_next = 1'b1;
                if (i_err) begin
                    w_err_next   = 1'b1;
                    w_fence_next = 1'b0;
                    w_state_next = IDLE;
                end else if (i_rty) begin
                    w_state_next = RETRY;
                end else if (i_ack) begin
                    o_word_we = 1'b1;
                    if (r_word == LAST_WORD) begin
                        // A fence seen now or earlier in the refill leaves the line invalid.
                        o_line_done     = 1'b1;
                        o_install_valid = !r_fence_pend && !i_fence;
                        w_fence_next    = 1'b0;
                        w_state_next    = IDLE;
                    end else begin
                        w_word_next = r_word + 1'b1;
                        w_adr_next  = r_adr + 32'd4;
                    end
                end
            end
            RETRY: begin
                if (i_fence) w_fence_next = 1'b1;
                w_state_next = REFILL;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_state = r_state;
    assign o_word  = r_word;
    assign o_line  = r_line;
    assign o_adr   = r_adr;
    assign o_cyc   = (r_state != IDLE);
    assign o_stb   = (r_state == REFILL);
    assign o_err   = r_err;
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with combinational hit path.
// Optional ICACHE_PERF_CNT_EN adds hit/miss performance counters.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic        fetch_en_i,
    output logic [31:0] inst_o,
    output logic        ready_o,
    input  logic        fence_i_i,
    output logic        err_o,
    icache_dm_if.master wb
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);
    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 30 - OFF_W - IDX_W;
    localparam int LINE_W = 30 - OFF_W;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag_arr  [0:LINES-1];
    logic [31:0]      r_data_arr [0:LINES*WORDS_PER_LINE-1];

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_match, w_idle, w_hit, w_miss;
    icache_state_e     w_state;
    logic              w_start, w_word_we, w_line_done, w_install_valid;
    logic [OFF_W-1:0]  w_word;
    logic [LINE_W-1:0] w_line;
    logic [IDX_W-1:0]  w_fill_idx;
    logic [TAG_W-1:0]  w_fill_tag;
    logic              w_unused;

    assign w_off      = pc_i[OFF_W+1:2];
    assign w_idx      = pc_i[OFF_W+IDX_W+1:OFF_W+2];
    assign w_tag      = pc_i[31:OFF_W+IDX_W+2];
    assign w_fill_idx = w_line[IDX_W-1:0];
    assign w_fill_tag = w_line[LINE_W-1:IDX_W];
    assign w_unused   = &{1'b0, pc_i[1:0]};

    assign w_idle  = (w_state == IDLE);
    assign w_match = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
    assign w_hit   = fetch_en_i && w_match && w_idle;
    assign w_miss  = fetch_en_i && !w_match;
    assign ready_o = w_hit;
    assign inst_o  = w_idle ? r_data_arr[{w_idx, w_off}] : 32'd0;

    icache_dm_refill_fsm #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .OFF_W          (OFF_W),
        .LINE_W         (LINE_W)
    ) u_refill (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_miss          (w_miss),
        .i_line          (pc_i[31:OFF_W+2]),
        .i_fence         (fence_i_i),
        .i_ack           (wb.wb_ack_i),
        .i_rty           (wb.wb_rty_i),
        .i_err           (wb.wb_err_i),
        .o_state         (w_state),
        .o_start         (w_start),
        .o_word_we       (w_word_we),
        .o_line_done     (w_line_done),
        .o_install_valid (w_install_valid),
        .o_word          (w_word),
        .o_line          (w_line),
        .o_adr           (wb.wb_adr_o),
        .o_cyc           (wb.wb_cyc_o),
        .o_stb           (wb.wb_stb_o),
        .o_err           (err_o)
    );

    assign wb.wb_dat_o = 32'd0;
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_sel_o = WB_SEL_ALL;

    // Valid bits: fence clears all, a new refill invalidates its line, completion installs it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            if (fence_i_i) r_valid <= '0;
            else if (w_start) r_valid[w_idx] <= 1'b0;
            if (w_install_valid) r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // Tag and data storage are left unreset; validity alone gates their use.
    always_ff @(posedge clk) begin
        if (w_word_we)   r_data_arr[{w_fill_idx, w_word}] <= wb.wb_dat_i;
        if (w_line_done) r_tag_arr[w_fill_idx] <= w_fill_tag;
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    // Free-running hit and miss counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit)   r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_start) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Directed testbench for icache_dm with a zero-wait Wishbone memory model and
// scoreboards for expected bus addresses and expected instructions.
module tb_icache_dm;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_i = 32'd0;
    logic        fetch_en_i = 1'b0;
    logic        fence_i_i = 1'b0;
    logic [31:0] inst_o;
    logic        ready_o;
    logic        err_o;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache_dm_if wb ();

    icache_dm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_i       (pc_i),
        .fetch_en_i (fetch_en_i),
        .inst_o     (inst_o),
        .ready_o    (ready_o),
        .fence_i_i  (fence_i_i),
        .err_o      (err_o),
        .wb         (wb)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_inst_q[$];
    logic        rty_arm = 1'b0, err_arm = 1'b0;
    logic [31:0] rty_adr = 32'd0, err_adr = 32'd0;
    logic        prev_rty = 1'b0, prev_err = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Zero-wait slave: acks every strobe; retry/error injected at one armed address.
    assign wb.wb_dat_i = mem_word(wb.wb_adr_o);
    assign wb.wb_ack_i = wb.wb_stb_o;
    assign wb.wb_rty_i = wb.wb_stb_o && rty_arm && (wb.wb_adr_o == rty_adr);
    assign wb.wb_err_i = wb.wb_stb_o && err_arm && (wb.wb_adr_o == err_adr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_adr_q.push_back(base + 32'(4 * i));
    endtask

    // One clock cycle: observe at the falling edge, advance past the rising edge.
    task automatic cycle(output logic rdy, output logic [31:0] inst);
        logic        f_rty, f_err;
        logic [31:0] e;
        @(negedge clk);
        rdy = ready_o;
        inst = inst_o;
        if (err_o) err_pulses++;
        if (prev_rty) begin
            check("retry_stb_low", {31'd0, wb.wb_stb_o}, 32'd0);
            check("retry_cyc_held", {31'd0, wb.wb_cyc_o}, 32'd1);
            check("retry_adr_held", wb.wb_adr_o, rty_adr);
        end
        if (prev_err) check("err_cyc_drop", {31'd0, wb.wb_cyc_o}, 32'd0);
        f_rty = wb.wb_stb_o && wb.wb_rty_i;
        f_err = wb.wb_stb_o && wb.wb_err_i;
        if (wb.wb_stb_o) begin
            if (exp_adr_q.size() == 0) begin
                check("bus_unexpected_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
            end else begin
                e = exp_adr_q.pop_front();
                check(f_err ? "err_adr" : (f_rty ? "rty_adr" : "wb_adr"), wb.wb_adr_o, e);
                if (f_rty && !f_err) exp_adr_q.push_front(e);
            end
        end
        @(posedge clk);
        #1;
        prev_rty = f_rty && !f_err;
        prev_err = f_err;
        if (f_rty) rty_arm = 1'b0;
        if (f_err) err_arm = 1'b0;
    endtask

    // Present a fetch until ready_o; check the instruction and the cycle count to the hit.
    task automatic fetch(input logic [31:0] pc, input int exp_lat, input int fence_at, input string tag);
        logic        rdy;
        logic [31:0] inst;
        bit          done = 1'b0;
        pc_i = pc;
        fetch_en_i = 1'b1;
        exp_inst_q.push_back(mem_word(pc));
        for (int n = 0; n < 40 && !done; n++) begin
            fence_i_i = (n == fence_at);
            cycle(rdy, inst);
            fence_i_i = 1'b0;
            if (rdy) begin
                done = 1'b1;
                check({tag, "_inst"}, inst, exp_inst_q.pop_front());
                check({tag, "_lat"}, 32'(n), 32'(exp_lat));
            end
        end
        if (!done) begin
            void'(exp_inst_q.pop_front());
            check({tag, "_timeout"}, {31'd0, done}, 32'd1);
        end
        fetch_en_i = 1'b0;
        $display("fetch %s pc=%h done=%0d", tag, pc, done);
    endtask

    initial begin
        logic        rdy;
        logic [31:0] inst;
        int          err_before;

        // Reset state, with a fetch already requested.
        pc_i = 32'h8000_0008;
        fetch_en_i = 1'b1;
        #12;
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        check("rst_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, wb.wb_stb_o}, 32'd0);
        check("rst_adr", wb.wb_adr_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("tie_sel", {28'd0, wb.wb_sel_o}, 32'hF);
        check("tie_we", {31'd0, wb.wb_we_o}, 32'd0);
        fetch_en_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss then hits within the line.
        push_line(32'h8000_0000);
        fetch(32'h8000_0008, 5, -1, "cold");
        check("cold_q_drained", 32'(exp_adr_q.size()), 32'd0);
        fetch(32'h8000_0004, 0, -1, "hit4");
        fetch(32'h8000_000C, 0, -1, "hit12");

        // Conflict eviction on index 0.
        push_line(32'h8000_0400);
        fetch(32'h8000_0400, 5, -1, "conflict");
        push_line(32'h8000_0000);
        fetch(32'h8000_0004, 5, -1, "evicted");

        // Retry on word 2 (ack asserted too: retry must win).
        rty_adr = 32'h8000_0108;
        rty_arm = 1'b1;
        push_line(32'h8000_0100);
        fetch(32'h8000_0108, 7, -1, "retry");
        fetch(32'h8000_0100, 0, -1, "retry_w0");
        fetch(32'h8000_010C, 0, -1, "retry_w3");

        // Error on word 1: line aborted, persistent fetch re-misses at once.
        err_adr = 32'h8000_0204;
        err_arm = 1'b1;
        exp_adr_q.push_back(32'h8000_0200);
        exp_adr_q.push_back(32'h8000_0204);
        push_line(32'h8000_0200);
        err_before = err_pulses;
        fetch(32'h8000_0200, 8, -1, "err_refetch");
        check("err_pulse_count", 32'(err_pulses - err_before), 32'd1);

        // Fence in IDLE invalidates every line.
        fence_i_i = 1'b1;
        cycle(rdy, inst);
        fence_i_i = 1'b0;
        push_line(32'h8000_0100);
        fetch(32'h8000_0108, 5, -1, "fence_idle_a");
        push_line(32'h8000_0200);
        fetch(32'h8000_0200, 5, -1, "fence_idle_b");

        // Fence during word 1: line completes invalid, then re-misses.
        push_line(32'h8000_0300);
        push_line(32'h8000_0300);
        fetch(32'h8000_0304, 10, 2, "fence_w1");
        push_line(32'h8000_0100);
        fetch(32'h8000_0100, 5, -1, "fence_other");

        // Fence coinciding with the final ack.
        push_line(32'h8000_0340);
        push_line(32'h8000_0340);
        fetch(32'h8000_0340, 10, 4, "fence_last");
        fetch(32'h8000_0340, 0, -1, "pre_reset_hit");

        // Asynchronous reset in the middle of a refill.
        push_line(32'h8000_0500);
        pc_i = 32'h8000_0500;
        fetch_en_i = 1'b1;
        cycle(rdy, inst);
        cycle(rdy, inst);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
        check("arst_stb", {31'd0, wb.wb_stb_o}, 32'd0);
        check("arst_adr", wb.wb_adr_o, 32'd0);
        check("arst_err", {31'd0, err_o}, 32'd0);
        $display("async reset applied mid-refill");
        exp_adr_q.delete();
        fetch_en_i = 1'b0;
        prev_rty = 1'b0;
        prev_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef ICACHE_PERF_CNT_EN
        check("perf_rst_hit", hit_cnt, 32'd0);
        check("perf_rst_miss", miss_cnt, 32'd0);
`endif
        push_line(32'h8000_0340);
        fetch(32'h8000_0340, 5, -1, "post_reset");
        for (int i = 0; i < 4; i++) fetch(32'h8000_0344, 0, -1, "post_hit");
`ifdef ICACHE_PERF_CNT_EN
        check("perf_hit", hit_cnt, 32'd5);
        check("perf_miss", miss_cnt, 32'd1);
`endif
        check("final_q_drained", 32'(exp_adr_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
